// File: rtl/add_16.sv
// 16-bit ripple-carry adder built from half/full adders, with registered
// sum, carry-out, signed-overflow and zero flags and a one-cycle valid strobe.

module add_16_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module add_16_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0;
  logic c0;
  logic c1;

  add_16_ha u_ha0 (.x(x),  .y(y),  .s(s0), .c(c0));
  add_16_ha u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

module add_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_next;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    add_16_fa u_fa (
      .x  (a[i]),
      .y  (b[i]),
      .ci (carry[i]),
      .s  (sum_next[i]),
      .co (carry[i+1])
    );
  end

  // Signed overflow comes from the MSB carries, independent of cout.
  logic overflow_next;
  assign overflow_next = carry[WIDTH-1] ^ carry[WIDTH];

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum      <= sum_next;
        cout     <= carry[WIDTH];
        overflow <= overflow_next;
        zero     <= (sum_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_add_16.sv
// Scoreboard bench for add_16: the driver pushes reference results into a
// queue, and an independent monitor pops and compares on every out_valid.

module tb_add_16;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;
  logic        zero;
  logic        out_valid;

  int checks = 0;
  int fails  = 0;

  exp_t sb[$];

  add_16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: plain 17-bit arithmetic and sign rules for overflow.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
    exp_t e;
    int unsigned total;
    total  = int'(x) + int'(y) + int'(c);
    e.sum  = total[15:0];
    e.cout = (total >= 32'h10000);
    e.ovf  = (x[15] == y[15]) && (e.sum[15] != x[15]);
    e.zero = (e.sum == 16'h0000);
    return e;
  endfunction

  // Drive one cycle's inputs; these are captured at the next rising edge.
  task automatic issue(input logic r, input logic v, input logic [15:0] x,
                       input logic [15:0] y, input logic c);
    rst      = r;
    in_valid = v;
    a        = x;
    b        = y;
    cin      = c;
    if (v && !r) sb.push_back(model(x, y, c));
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [15:0] x, input logic [15:0] y, input logic c);
    issue(1'b0, 1'b1, x, y, c);
  endtask

  // Monitor: inputs are stable at the falling edge, so record what the next
  // rising edge will see and judge the outputs of the previous one.
  initial begin
    logic p_rst   = 1'b1;
    logic p_valid = 1'b1;
    exp_t held    = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (p_rst) begin
        check("rst_out_valid", out_valid, 0);
        check("rst_sum",       sum,       0);
        check("rst_cout",      cout,      0);
        check("rst_overflow",  overflow,  0);
        check("rst_zero",      zero,      0);
        held = '0;
      end else begin
        check("out_valid", out_valid, p_valid);
        if (out_valid === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard: got out_valid with no pending operation (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            check("sum",      sum,      e.sum);
            check("cout",     cout,     e.cout);
            check("overflow", overflow, e.ovf);
            check("zero",     zero,     e.zero);
            held = e;
          end
        end else begin
          check("hold_sum",      sum,      held.sum);
          check("hold_cout",     cout,     held.cout);
          check("hold_overflow", overflow, held.ovf);
          check("hold_zero",     zero,     held.zero);
        end
      end
      p_rst   = rst;
      p_valid = in_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with live operands: must stay cleared throughout.
    rst = 1'b1; in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0;
    @(posedge clk); #1;
    issue(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);

    // Basic and carry-in, back to back.
    op(16'h0001, 16'h0002, 1'b0);
    op(16'h0001, 16'h0002, 1'b1);
    op(16'h0005, 16'h0003, 1'b0);
    op(16'h1234, 16'h5678, 1'b0);
    op(16'h1234, 16'h5678, 1'b1);

    // Overflow and wrap.
    op(16'hFFFF, 16'hFFFF, 1'b0);
    op(16'hFFFF, 16'hFFFF, 1'b1);
    op(16'h8000, 16'h8000, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0);

    // Carry propagation.
    op(16'h00FF, 16'h0001, 1'b0);
    op(16'h0FFF, 16'h0001, 1'b0);
    op(16'hFFFE, 16'h0001, 1'b0);
    op(16'h5555, 16'hAAAA, 1'b0);
    op(16'h5555, 16'hAAAA, 1'b1);

    // Hold and identity.
    op(16'hABCD, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++)
      issue(1'b0, 1'b0, 16'(i * 16'h1111), 16'h2222, 1'b1);
    op(16'h0000, 16'h0000, 1'b0);

    // Reset priority, then resume.
    issue(1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0);
    op(16'h1234, 16'h5678, 1'b0);
    op(16'h8000, 16'h7FFF, 1'b1);

    // Randomised traffic with idle gaps.
    for (int i = 0; i < 300; i++)
      issue(1'b0, ($urandom_range(3) != 0), 16'($urandom), 16'($urandom), 1'($urandom));

    for (int i = 0; i < 3; i++)
      issue(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
